// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_pkg
// Purpose  : Shared pipeline definitions for the instruction-fetch stage:
//            reset PC default, NOP encoding, instruction field positions,
//            fetch state encoding and a word-alignment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  // sll $0,$0,0 encodes as all zeros
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:29] hi, input logic [28:2] lo);
    return {hi, lo, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : Bundle of fetch-stage bus signals: hazard holds, branch
//            redirect, instruction-memory port, IF/ID outputs and counters.
// Ports    : modport master - the fetch stage (drives PC, imem_addr, IF/ID)
//            modport slave  - surrounding pipeline / instruction memory
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic         PCWrite;
  logic         IFIDWrite;
  logic         branch_taken;
  logic [31:0]  branch_target;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_rdata;
  logic [31:0]  pc;
  logic [31:0]  IFID_instr;
  logic [31:0]  IFID_pc4;
  logic         IFID_valid;
  logic [4:0]   IFID_rs;
  logic [4:0]   IFID_rt;
  logic [31:0]  fetch_count;
  logic [15:0]  stall_count;
  fetch_state_t state;

  modport master (
    input  PCWrite, IFIDWrite, branch_taken, branch_target, imem_rdata,
    output imem_addr, pc, IFID_instr, IFID_pc4, IFID_valid, IFID_rs, IFID_rt,
           fetch_count, stall_count, state
  );

  modport slave (
    output PCWrite, IFIDWrite, branch_taken, branch_target, imem_rdata,
    input  imem_addr, pc, IFID_instr, IFID_pc4, IFID_valid, IFID_rs, IFID_rt,
           fetch_count, stall_count, state
  );

endinterface
`default_nettype wire

// File: rtl/fetch_stage_ifid_reg.sv
`default_nettype none
// ============================================================================
// Module   : ifid_reg
// Purpose  : IF/ID pipeline register with hold, flush and valid bit.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            flush         - replace contents with NOP (valid=0)
//            hold          - keep all fields unchanged
//            instr_in/pc4_in - fetched word and its PC+4
//            instr/pc4/valid - registered outputs
//            load          - this edge captures a new valid word
// Revision : 1.0 - initial release
// ============================================================================
module ifid_reg
  import fetch_stage_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        flush,
  input  wire logic        hold,
  input  wire logic [31:0] instr_in,
  input  wire logic [31:0] pc4_in,
  output logic      [31:0] instr,
  output logic      [31:0] pc4,
  output logic             valid,
  output logic             load
);

  // Flush beats hold: a redirect comes from an older instruction.
  assign load = !rst && !flush && !hold;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr <= NOP_WORD;
      pc4   <= 32'h0000_0000;
      valid <= 1'b0;
    end else if (!hold) begin
      instr <= instr_in;
      pc4   <= pc4_in;
      valid <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : MIPS instruction-fetch stage: PC register, next-PC selection,
//            IF/ID register, fetch/stall counters and fetch state.
// Ports    : clk  - rising-edge clock
//            rst  - synchronous active-high reset
//            bus  - fetch_stage_if.master (holds, redirect, imem, IF/ID,
//                   counters, state)
// Params   : RESET_PC - word-aligned PC loaded on reset
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  wire logic   clk,
  input  wire logic   rst,
  fetch_stage_if.master bus
);

  logic [31:0]  pc_r;
  logic [31:0]  pc_plus4;
  logic [31:0]  pc_next;
  logic [31:0]  fetch_count_r;
  logic [15:0]  stall_count_r;
  fetch_state_t state_r;
  logic         ifid_load;
  logic         unused_target_bits;

  // Low target bits are forced to zero and never looked at.
  assign unused_target_bits = ^bus.branch_target[1:0];

  // 32-bit modulo increment; wrap past 0xFFFF_FFFC is intentional.
  assign pc_plus4 = pc_r + 32'd4;

  always_comb begin
    pc_next = pc_plus4;
    if (bus.branch_taken) begin
      pc_next = word_align(bus.branch_target[31:29], bus.branch_target[28:2]);
    end else if (bus.PCWrite) begin
      pc_next = pc_r;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next;
    end
  end

  ifid_reg u_ifid_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.branch_taken),
    .hold     (bus.IFIDWrite),
    .instr_in (bus.imem_rdata),
    .pc4_in   (pc_plus4),
    .instr    (bus.IFID_instr),
    .pc4      (bus.IFID_pc4),
    .valid    (bus.IFID_valid),
    .load     (ifid_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_r <= 32'd0;
      stall_count_r <= 16'd0;
    end else begin
      if (ifid_load) begin
        fetch_count_r <= fetch_count_r + 32'd1;
      end
      // A redirect cycle is not a hazard stall even if the hold is raised.
      if (bus.PCWrite && !bus.branch_taken && (stall_count_r != 16'hFFFF)) begin
        stall_count_r <= stall_count_r + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN, ST_STALL, ST_FLUSH: begin
          if (bus.branch_taken) begin
            state_r <= ST_FLUSH;
          end else if (bus.PCWrite) begin
            state_r <= ST_STALL;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: state_r <= ST_RUN;
      endcase
    end
  end

  assign bus.imem_addr   = pc_r;
  assign bus.pc          = pc_r;
  assign bus.IFID_rs     = bus.IFID_instr[RS_MSB:RS_LSB];
  assign bus.IFID_rt     = bus.IFID_instr[RT_MSB:RT_LSB];
  assign bus.fetch_count = fetch_count_r;
  assign bus.stall_count = stall_count_r;
  assign bus.state       = state_r;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage (default and wrapping
//            RESET_PC instances) using a scoreboard of expected states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst1;
  always #5 clk = ~clk;

  fetch_stage_if bus0();
  fetch_stage_if bus1();

  fetch_stage u_dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1.master));

  // Instruction memory model: word = address ^ A5A5_0000.
  assign bus0.imem_rdata = bus0.imem_addr ^ 32'hA5A5_0000;
  assign bus1.imem_rdata = bus1.imem_addr ^ 32'hA5A5_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] fc;
    logic [15:0] sc;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc, m_instr, m_pc4, m_fc;
  logic        m_valid;
  logic [15:0] m_sc;

  function automatic exp_t observe();
    return {bus0.pc, bus0.IFID_instr, bus0.IFID_pc4, bus0.IFID_valid,
            bus0.fetch_count, bus0.stall_count};
  endfunction

  // Drive one cycle, update the reference model, push the expectation.
  task automatic drive(input logic r, input logic pcw, input logic ifw,
                       input logic bt, input logic [31:0] tgt);
    rst                = r;
    bus0.PCWrite       = pcw;
    bus0.IFIDWrite     = ifw;
    bus0.branch_taken  = bt;
    bus0.branch_target = tgt;
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_fc = 32'h0; m_sc = 16'h0;
    end else begin
      if (pcw && !bt && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (bt) begin
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_pc = {tgt[31:2], 2'b00};
      end else begin
        if (!ifw) begin
          m_instr = m_pc ^ 32'hA5A5_0000;
          m_pc4   = m_pc + 32'd4;
          m_valid = 1'b1;
          m_fc    = m_fc + 32'd1;
        end
        if (!pcw) m_pc = m_pc + 32'd4;
      end
    end
    sb.push_back({m_pc, m_instr, m_pc4, m_valid, m_fc, m_sc});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    drive(1, 0, 0, 0, 32'h0);
    drive(1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front(); o = observe();
      if (i == 1) begin
        n_tests++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL reset_state: got %h expected %h", o, e);
        end
      end
    end
    n_tests++;
    if (bus0.imem_addr !== 32'h0 || bus0.IFID_rs !== 5'd0 || bus0.IFID_rt !== 5'd0
        || bus0.state !== ST_RUN) begin
      n_fail++;
      $display("FAIL reset_misc: got addr=%h rs=%0d rt=%0d st=%0d expected 0/0/0/0",
               bus0.imem_addr, bus0.IFID_rs, bus0.IFID_rt, bus0.state);
    end
  endtask

  task automatic test_free_run();
    exp_t e, o;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 32'h0);
      e = sb.pop_front(); o = observe();
      n_tests++;
      if (o !== e || bus0.IFID_pc4 !== 32'(4 * (i + 1)) || bus0.IFID_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL free_run[%0d]: got %h expected %h", i, o, e);
      end
      n_tests++;
      if (bus0.IFID_rs !== e.instr[25:21] || bus0.IFID_rt !== e.instr[20:16]) begin
        n_fail++;
        $display("FAIL rs_rt[%0d]: got %0d/%0d expected %0d/%0d", i,
                 bus0.IFID_rs, bus0.IFID_rt, e.instr[25:21], e.instr[20:16]);
      end
    end
    n_tests++;
    if (bus0.fetch_count !== 32'd4) begin
      n_fail++;
      $display("FAIL free_run_count: got %0d expected 4", bus0.fetch_count);
    end
  endtask

  task automatic test_stall();
    exp_t e, o;
    drive(1, 0, 0, 0, 32'h0);
    void'(sb.pop_front());
    drive(0, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    void'(sb.pop_front());
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 32'h0);
      e = sb.pop_front(); o = observe();
      n_tests++;
      if (o !== e || bus0.pc !== 32'h8 || bus0.state !== ST_STALL) begin
        n_fail++;
        $display("FAIL stall[%0d]: got %h st=%0d expected %h st=1", i, o, bus0.state, e);
      end
    end
    n_tests++;
    if (bus0.stall_count !== 16'd3 || bus0.fetch_count !== 32'd2) begin
      n_fail++;
      $display("FAIL stall_counts: got sc=%0d fc=%0d expected sc=3 fc=2",
               bus0.stall_count, bus0.fetch_count);
    end
    drive(0, 0, 0, 0, 32'h0);
    e = sb.pop_front(); o = observe();
    n_tests++;
    if (o !== e || bus0.IFID_pc4 !== 32'hC || bus0.state !== ST_RUN) begin
      n_fail++;
      $display("FAIL stall_resume: got %h expected %h", o, e);
    end
  endtask

  task automatic test_branch();
    exp_t e, o;
    drive(0, 0, 0, 1, 32'h0000_0103);
    e = sb.pop_front(); o = observe();
    n_tests++;
    if (o !== e || bus0.pc !== 32'h100 || bus0.IFID_valid !== 1'b0 || bus0.state !== ST_FLUSH) begin
      n_fail++;
      $display("FAIL branch: got %h st=%0d expected %h st=2", o, bus0.state, e);
    end
    drive(0, 0, 0, 0, 32'h0);
    e = sb.pop_front(); o = observe();
    n_tests++;
    if (o !== e || bus0.IFID_instr !== 32'hA5A5_0100 || bus0.IFID_pc4 !== 32'h104) begin
      n_fail++;
      $display("FAIL branch_target_fetch: got %h expected %h", o, e);
    end
  endtask

  task automatic test_branch_stall();
    exp_t e, o;
    logic [15:0] sc_before;
    sc_before = bus0.stall_count;
    drive(0, 1, 1, 1, 32'h0000_0200);
    e = sb.pop_front(); o = observe();
    n_tests++;
    if (o !== e || bus0.pc !== 32'h200 || bus0.IFID_valid !== 1'b0 ||
        bus0.stall_count !== sc_before) begin
      n_fail++;
      $display("FAIL branch_over_stall: got %h expected %h", o, e);
    end
    drive(0, 0, 0, 0, 32'h0);
    e = sb.pop_front(); o = observe();
    n_tests++;
    if (o !== e || bus0.IFID_pc4 !== 32'h204) begin
      n_fail++;
      $display("FAIL branch_over_stall_next: got %h expected %h", o, e);
    end
  endtask

  task automatic test_wrap();
    rst1 = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bus1.pc !== 32'hFFFF_FFFC || bus1.IFID_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_reset: got pc=%h v=%b expected fffffffc/0", bus1.pc, bus1.IFID_valid);
    end
    rst1 = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (bus1.pc !== 32'h0 || bus1.IFID_pc4 !== 32'h0 || bus1.IFID_instr !== 32'h5A5A_FFFC
        || bus1.IFID_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_edge1: got pc=%h pc4=%h instr=%h expected 0/0/5a5afffc",
               bus1.pc, bus1.IFID_pc4, bus1.IFID_instr);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus1.pc !== 32'h4 || bus1.IFID_pc4 !== 32'h4 || bus1.fetch_count !== 32'd2) begin
      n_fail++;
      $display("FAIL wrap_edge2: got pc=%h pc4=%h fc=%0d expected 4/4/2",
               bus1.pc, bus1.IFID_pc4, bus1.fetch_count);
    end
  endtask

  task automatic test_rst_mid();
    exp_t e, o;
    drive(1, 0, 0, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, 32'h0);
    while (sb.size() > 1) void'(sb.pop_front());
    e = sb.pop_front(); o = observe();
    n_tests++;
    if (o !== e || bus0.stall_count !== 16'd5) begin
      n_fail++;
      $display("FAIL pre_rst_stall: got %h expected %h", o, e);
    end
    drive(1, 1, 1, 1, 32'h0000_0400);
    e = sb.pop_front(); o = observe();
    n_tests++;
    if (o !== e || bus0.pc !== 32'h0 || bus0.stall_count !== 16'd0 || bus0.state !== ST_RUN) begin
      n_fail++;
      $display("FAIL rst_mid: got %h expected %h", o, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                = 1'b1;
    rst1               = 1'b1;
    bus0.PCWrite       = 1'b0;
    bus0.IFIDWrite     = 1'b0;
    bus0.branch_taken  = 1'b0;
    bus0.branch_target = 32'h0;
    bus1.PCWrite       = 1'b0;
    bus1.IFIDWrite     = 1'b0;
    bus1.branch_taken  = 1'b0;
    bus1.branch_target = 32'h0;
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
